mem_pager_regs: RTL



---
 rtl/mem_pager_regs.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mem_pager_regs.sv
// mem_pager_regs: Z80 I/O-port register block feeding the memory mapper.
// Synchronises the Z80 bus into clk, decodes one I/O access per Z80 cycle,
// and holds the MPAG (00h), MPAGEX (10h) and GSCFG0 (0Fh) registers plus
// the derived page/mode outputs.
// Ports:
//   clk, rst          - FPGA clock (>= 4x Z80 clock), sync active-high reset
//   a, din            - Z80 address low byte and data bus (asynchronous)
//   iorq_n, rd_n,
//   wr_n, m1_n        - Z80 bus control (asynchronous, active low)
//   dout, dout_en     - readback data and Z80 data-bus drive enable
//   mode_pg0/pg1      - pages for $8000-$BFFF / $C000-$FFFF
//   mode_ramro        - RAM pages 0/1 read-only
//   mode_norom        - RAM mapped in place of ROM
module mem_pager_regs (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] din,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       m1_n,
    output logic [7:0] dout,
    output logic       dout_en,
    output logic [6:0] mode_pg0,
    output logic [6:0] mode_pg1,
    output logic       mode_ramro,
    output logic       mode_norom
);

    localparam int unsigned DW  = 8;
    localparam int unsigned PGW = 7;
    localparam int unsigned CW  = 4;

    localparam logic [DW-1:0] PORT_MPAG   = 8'h00;
    localparam logic [DW-1:0] PORT_MPAGEX = 8'h10;
    localparam logic [DW-1:0] PORT_GSCFG0 = 8'h0F;

    // Control vector order: {iorq_n, rd_n, wr_n, m1_n}; idle is all ones.
    localparam logic [CW-1:0] CTL_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_READ     = 2'd2,
        ST_WAIT_END = 2'd3
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   ctl_s1_q, ctl_s2_q;
    logic [DW-1:0]   a_s1_q, a_s2_q;
    logic [DW-1:0]   d_s1_q, d_s2_q;
    logic [DW-1:0]   mpag_q, mpagex_q, gscfg0_q;
    logic [PGW-1:0]  pg0_q, pg1_q;
    logic [DW-1:0]   dout_q;
    logic            dout_en_q;

    // Decode of the synchronised bus (s2 stage only).
    logic            iorq_s2, rd_s2, wr_s2, m1_s2;
    logic            io_cycle, wr_req, rd_req, bad_req;
    logic            expag;
    logic            rd_hit;
    logic [DW-1:0]   rd_data;

    assign iorq_s2  = ctl_s2_q[3];
    assign rd_s2    = ctl_s2_q[2];
    assign wr_s2    = ctl_s2_q[1];
    assign m1_s2    = ctl_s2_q[0];

    // m1 low with iorq low is an interrupt acknowledge, not a port access.
    assign io_cycle = !iorq_s2 && m1_s2;
    assign wr_req   = io_cycle && !wr_s2 &&  rd_s2;
    assign rd_req   = io_cycle && !rd_s2 &&  wr_s2;
    assign bad_req  = io_cycle && !rd_s2 && !wr_s2;
    assign expag    = gscfg0_q[3];

    // Readback mux for the decoded port.
    always_comb begin
        rd_hit  = 1'b1;
        rd_data = '0;
        case (a_s2_q)
            PORT_MPAG:   rd_data = mpag_q;
            PORT_MPAGEX: rd_data = mpagex_q;
            PORT_GSCFG0: rd_data = gscfg0_q;
            default:     rd_hit  = 1'b0;
        endcase
    end

    // Two-flop synchroniser for control, address and data.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_s1_q <= CTL_IDLE;
            ctl_s2_q <= CTL_IDLE;
            a_s1_q   <= '0;
            a_s2_q   <= '0;
            d_s1_q   <= '0;
            d_s2_q   <= '0;
        end else begin
            ctl_s1_q <= {iorq_n, rd_n, wr_n, m1_n};
            ctl_s2_q <= ctl_s1_q;
            a_s1_q   <= a;
            a_s2_q   <= a_s1_q;
            d_s1_q   <= din;
            d_s2_q   <= d_s1_q;
        end
    end

    // Access FSM. The register commit / readback load happens on the edge
    // that enters WRITE / READ, giving the E3 output latency; the FSM then
    // parks in WAIT_END so a long Z80 cycle commits only once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mpag_q    <= '0;
            mpagex_q  <= '0;
            gscfg0_q  <= '0;
            pg0_q     <= 7'd0;
            pg1_q     <= 7'd1;
            dout_q    <= '0;
            dout_en_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (wr_req) begin
                        state_q <= ST_WRITE;
                        case (a_s2_q)
                            PORT_MPAG: begin
                                mpag_q <= d_s2_q;
                                if (expag) begin
                                    pg0_q <= d_s2_q[6:0];
                                end else begin
                                    pg0_q <= {d_s2_q[5:0], 1'b0};
                                    pg1_q <= {d_s2_q[5:0], 1'b1};
                                end
                            end
                            PORT_MPAGEX: begin
                                mpagex_q <= d_s2_q;
                                if (expag) begin
                                    pg1_q <= d_s2_q[6:0];
                                end
                            end
                            PORT_GSCFG0: gscfg0_q <= d_s2_q;
                            default: ;
                        endcase
                    end else if (rd_req) begin
                        state_q <= ST_READ;
                        if (rd_hit) begin
                            dout_q    <= rd_data;
                            dout_en_q <= 1'b1;
                        end
                    end else if (bad_req) begin
                        state_q <= ST_WAIT_END;
                    end
                end
                ST_WRITE: state_q <= ST_WAIT_END;
                ST_READ:  state_q <= ST_WAIT_END;
                ST_WAIT_END: begin
                    if (iorq_s2) begin
                        state_q   <= ST_IDLE;
                        dout_en_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_en    = dout_en_q;
    assign mode_pg0   = pg0_q;
    assign mode_pg1   = pg1_q;
    assign mode_norom = gscfg0_q[0];
    assign mode_ramro = gscfg0_q[1];

endmodule
